// File: rtl/ase_pcie_ss_rd_cpl_splitter.sv
// ase_pcie_ss_rd_cpl_splitter
// Takes one host DMA read request at a time and presents it as a sequence of
// completion segments. The first segment is trimmed so that it ends on a
// request-completion boundary; every later segment then starts aligned and is
// at most MAX_CPL_BYTES long. A per-tag busy bitmap rejects a tag that is
// still in flight, and outstanding_cnt reports how many tags are busy.
// MAX_OUTSTANDING must be at least 2 so that the tag index has a width.

module ase_pcie_ss_rd_cpl_splitter #(
    parameter int MAX_OUTSTANDING  = 256,
    parameter int TAG_W            = 10,
    parameter int MAX_RD_REQ_BYTES = 4096,
    parameter int RCB_BYTES        = 64,
    parameter int MAX_CPL_BYTES    = 256,
    parameter int LEN_W            = 13
) (
    input  logic               clk,
    input  logic               rst_n,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic [TAG_W-1:0]   req_tag,
    input  logic [63:0]        req_addr,
    input  logic [LEN_W-1:0]   req_len,

    output logic               cpl_valid,
    input  logic               cpl_ready,
    output logic [TAG_W-1:0]   cpl_tag,
    output logic [63:0]        cpl_addr,
    output logic [LEN_W-1:0]   cpl_len,
    output logic [LEN_W-1:0]   cpl_byte_count,
    output logic               cpl_last,

    output logic               err_valid,
    output logic [1:0]         err_code,
    output logic [TAG_W:0]     outstanding_cnt
);

    localparam int RCB_LG    = $clog2(RCB_BYTES);
    localparam int TAG_IDX_W = $clog2(MAX_OUTSTANDING);

    localparam logic [TAG_W:0]   MAX_TAG_L = (TAG_W+1)'(MAX_OUTSTANDING);
    localparam logic [LEN_W-1:0] MAX_REQ_L = LEN_W'(MAX_RD_REQ_BYTES);
    localparam logic [LEN_W-1:0] MAX_CPL_L = LEN_W'(MAX_CPL_BYTES);

    localparam logic [1:0] ERR_BAD_TAG  = 2'd1;
    localparam logic [1:0] ERR_TAG_BUSY = 2'd2;
    localparam logic [1:0] ERR_BAD_LEN  = 2'd3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } state_t;

    state_t                 state_reg;
    logic                   req_ready_reg;
    logic                   cpl_valid_reg;
    logic [TAG_W-1:0]       cpl_tag_reg;
    logic [63:0]            cpl_addr_reg;
    logic [LEN_W-1:0]       cpl_len_reg;
    logic [LEN_W-1:0]       cpl_byte_count_reg;
    logic                   cpl_last_reg;
    logic                   err_valid_reg;
    logic [1:0]             err_code_reg;
    logic [TAG_W:0]         outstanding_cnt_reg;

    logic [MAX_OUTSTANDING-1:0] busy_reg;
    logic [MAX_OUTSTANDING-1:0] busy_next;

    logic                   tag_bad;
    logic                   tag_busy;
    logic                   len_bad;
    logic                   req_fire;
    logic                   set_en;
    logic                   clr_en;
    logic [TAG_IDX_W-1:0]   req_idx;
    logic [TAG_IDX_W-1:0]   cpl_idx;

    logic [LEN_W-1:0]       first_seg_next;
    logic [63:0]            addr_next;
    logic [LEN_W-1:0]       rem_next;
    logic [LEN_W-1:0]       seg_next;

    // Payload of the segment starting at a given RCB offset with rem bytes
    // left: never crosses the boundary that follows MAX_CPL_BYTES from the
    // last aligned point, and never exceeds what is left.
    function automatic logic [LEN_W-1:0] seg_len(input logic [RCB_LG-1:0] off,
                                                 input logic [LEN_W-1:0]  rem);
        logic [LEN_W-1:0] lim;
        lim = MAX_CPL_L - LEN_W'(off);
        return (rem < lim) ? rem : lim;
    endfunction

    assign req_idx  = req_tag[TAG_IDX_W-1:0];
    assign cpl_idx  = cpl_tag_reg[TAG_IDX_W-1:0];

    // Request checks and the next segment after the current one is taken.
    always_comb begin
        tag_bad        = ({1'b0, req_tag} >= MAX_TAG_L);
        tag_busy       = busy_reg[req_idx];
        len_bad        = (req_len == '0) || (req_len > MAX_REQ_L);
        req_fire       = (state_reg == IDLE) && req_valid && req_ready_reg;
        set_en         = req_fire && !tag_bad && !tag_busy && !len_bad;
        clr_en         = (state_reg == SPLIT) && cpl_valid_reg && cpl_ready && cpl_last_reg;
        first_seg_next = seg_len(req_addr[RCB_LG-1:0], req_len);
        addr_next      = cpl_addr_reg + 64'(cpl_len_reg);
        rem_next       = cpl_byte_count_reg - cpl_len_reg;
        seg_next       = seg_len(addr_next[RCB_LG-1:0], rem_next);
    end

    // Per-tag busy bit: set on a good request, cleared by its last segment.
    genvar gi;
    generate
        for (gi = 0; gi < MAX_OUTSTANDING; gi++) begin : g_busy
            always_comb begin
                busy_next[gi] = busy_reg[gi];
                if (set_en && (req_idx == TAG_IDX_W'(gi)))
                    busy_next[gi] = 1'b1;
                else if (clr_en && (cpl_idx == TAG_IDX_W'(gi)))
                    busy_next[gi] = 1'b0;
            end
        end
    endgenerate

    // Busy bitmap register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy_reg <= '0;
        else
            busy_reg <= busy_next;
    end

    // Accept/split FSM with all handshake and completion outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg           <= IDLE;
            req_ready_reg       <= 1'b1;
            cpl_valid_reg       <= 1'b0;
            cpl_tag_reg         <= '0;
            cpl_addr_reg        <= '0;
            cpl_len_reg         <= '0;
            cpl_byte_count_reg  <= '0;
            cpl_last_reg        <= 1'b0;
            err_valid_reg       <= 1'b0;
            err_code_reg        <= '0;
            outstanding_cnt_reg <= '0;
        end else begin
            err_valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    req_ready_reg <= 1'b1;
                    if (req_fire) begin
                        if (tag_bad) begin
                            err_valid_reg <= 1'b1;
                            err_code_reg  <= ERR_BAD_TAG;
                        end else if (tag_busy) begin
                            err_valid_reg <= 1'b1;
                            err_code_reg  <= ERR_TAG_BUSY;
                        end else if (len_bad) begin
                            err_valid_reg <= 1'b1;
                            err_code_reg  <= ERR_BAD_LEN;
                        end else begin
                            state_reg           <= SPLIT;
                            req_ready_reg       <= 1'b0;
                            cpl_valid_reg       <= 1'b1;
                            cpl_tag_reg         <= req_tag;
                            cpl_addr_reg        <= req_addr;
                            cpl_len_reg         <= first_seg_next;
                            cpl_byte_count_reg  <= req_len;
                            cpl_last_reg        <= (first_seg_next == req_len);
                            outstanding_cnt_reg <= outstanding_cnt_reg + (TAG_W+1)'(1);
                        end
                    end
                end
                SPLIT: begin
                    req_ready_reg <= 1'b0;
                    if (cpl_valid_reg && cpl_ready) begin
                        if (cpl_last_reg) begin
                            state_reg           <= IDLE;
                            req_ready_reg       <= 1'b1;
                            cpl_valid_reg       <= 1'b0;
                            cpl_last_reg        <= 1'b0;
                            outstanding_cnt_reg <= outstanding_cnt_reg - (TAG_W+1)'(1);
                        end else begin
                            cpl_addr_reg       <= addr_next;
                            cpl_len_reg        <= seg_next;
                            cpl_byte_count_reg <= rem_next;
                            cpl_last_reg       <= (seg_next == rem_next);
                        end
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    req_ready_reg <= 1'b1;
                    cpl_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    // Releasing a tag that is not marked busy means the bookkeeping is broken.
    a_release_busy: assert property (@(posedge clk) disable iff (!rst_n)
        clr_en |-> busy_reg[cpl_idx]);

    assign req_ready       = req_ready_reg;
    assign cpl_valid       = cpl_valid_reg;
    assign cpl_tag         = cpl_tag_reg;
    assign cpl_addr        = cpl_addr_reg;
    assign cpl_len         = cpl_len_reg;
    assign cpl_byte_count  = cpl_byte_count_reg;
    assign cpl_last        = cpl_last_reg;
    assign err_valid       = err_valid_reg;
    assign err_code        = err_code_reg;
    assign outstanding_cnt = outstanding_cnt_reg;

endmodule

// File: tb/tb_ase_pcie_ss_rd_cpl_splitter.sv
// Bench for ase_pcie_ss_rd_cpl_splitter: directed sequences for the listed
// scenarios, a table of request vectors, and random requests checked against
// a segment-list model. Inputs change and outputs are sampled on negedge.

module tb_ase_pcie_ss_rd_cpl_splitter;

    localparam int MAX_OUTSTANDING  = 256;
    localparam int TAG_W            = 10;
    localparam int MAX_RD_REQ_BYTES = 4096;
    localparam int RCB_BYTES        = 64;
    localparam int MAX_CPL_BYTES    = 256;
    localparam int LEN_W            = 13;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [TAG_W-1:0]   req_tag = '0;
    logic [63:0]        req_addr = '0;
    logic [LEN_W-1:0]   req_len = '0;
    logic               cpl_valid;
    logic               cpl_ready = 1'b0;
    logic [TAG_W-1:0]   cpl_tag;
    logic [63:0]        cpl_addr;
    logic [LEN_W-1:0]   cpl_len;
    logic [LEN_W-1:0]   cpl_byte_count;
    logic               cpl_last;
    logic               err_valid;
    logic [1:0]         err_code;
    logic [TAG_W:0]     outstanding_cnt;

    int tests = 0;
    int fails = 0;

    ase_pcie_ss_rd_cpl_splitter #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .TAG_W           (TAG_W),
        .MAX_RD_REQ_BYTES(MAX_RD_REQ_BYTES),
        .RCB_BYTES       (RCB_BYTES),
        .MAX_CPL_BYTES   (MAX_CPL_BYTES),
        .LEN_W           (LEN_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_tag        (req_tag),
        .req_addr       (req_addr),
        .req_len        (req_len),
        .cpl_valid      (cpl_valid),
        .cpl_ready      (cpl_ready),
        .cpl_tag        (cpl_tag),
        .cpl_addr       (cpl_addr),
        .cpl_len        (cpl_len),
        .cpl_byte_count (cpl_byte_count),
        .cpl_last       (cpl_last),
        .err_valid      (err_valid),
        .err_code       (err_code),
        .outstanding_cnt(outstanding_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        logic [63:0] addr;
        int          len;
        int          hold;
        int          exp_code;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called on a negedge; presents one request for one cycle.
    task automatic send_req(input int tag, input logic [63:0] addr, input int len);
        chk("req_ready_before_req", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_tag   = TAG_W'(tag);
        req_addr  = addr;
        req_len   = LEN_W'(len);
        @(negedge clk);
        req_valid = 1'b0;
        $display("[TB] req tag=%0d addr=0x%0h len=%0d", tag, addr, len);
    endtask

    // Checks the currently presented segment, optionally backpressured for
    // hold cycles (outputs must stay put), then takes it.
    task automatic expect_seg(input int tag, input logic [63:0] addr, input int len,
                              input int bc, input bit last, input int hold);
        cpl_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            chk("hold_valid", 64'(cpl_valid), 64'd1);
            chk("hold_addr",  cpl_addr, addr);
            chk("hold_len",   64'(cpl_len), 64'(len));
            chk("hold_bc",    64'(cpl_byte_count), 64'(bc));
            @(negedge clk);
        end
        chk("cpl_valid", 64'(cpl_valid), 64'd1);
        chk("cpl_tag",   64'(cpl_tag), 64'(tag));
        chk("cpl_addr",  cpl_addr, addr);
        chk("cpl_len",   64'(cpl_len), 64'(len));
        chk("cpl_bc",    64'(cpl_byte_count), 64'(bc));
        chk("cpl_last",  64'(cpl_last), 64'(last));
        chk("busy_cnt",  64'(outstanding_cnt), 64'd1);
        chk("ready_low", 64'(req_ready), 64'd0);
        chk("no_err",    64'(err_valid), 64'd0);
        $display("[TB] seg tag=%0d addr=0x%0h len=%0d bc=%0d last=%0d", cpl_tag, cpl_addr,
                 cpl_len, cpl_byte_count, cpl_last);
        cpl_ready = 1'b1;
        @(negedge clk);
        cpl_ready = 1'b0;
    endtask

    task automatic expect_idle();
        chk("idle_valid", 64'(cpl_valid), 64'd0);
        chk("idle_ready", 64'(req_ready), 64'd1);
        chk("idle_cnt",   64'(outstanding_cnt), 64'd0);
    endtask

    task automatic expect_err(input int code);
        chk("err_valid", 64'(err_valid), 64'd1);
        chk("err_code",  64'(err_code), 64'(code));
        chk("err_no_cpl", 64'(cpl_valid), 64'd0);
        chk("err_cnt",   64'(outstanding_cnt), 64'd0);
        $display("[TB] err code=%0d", err_code);
        @(negedge clk);
        chk("err_pulse", 64'(err_valid), 64'd0);
        chk("err_no_cpl2", 64'(cpl_valid), 64'd0);
        expect_idle();
    endtask

    // Reference: classify the request, then walk it as a list of segments,
    // each running to the next completion boundary reachable within
    // MAX_CPL_BYTES of the last RCB-aligned point, or to the end.
    function automatic int model_code(input int tag, input int len);
        if (tag >= MAX_OUTSTANDING) return 1;
        if (len == 0 || len > MAX_RD_REQ_BYTES) return 3;
        return 0;
    endfunction

    task automatic run_model(input int tag, input logic [63:0] addr, input int len,
                             input int code, input int hold_first, input bit rand_bp);
        logic [63:0] a;
        int r, lim, s, hold;
        send_req(tag, addr, len);
        if (code != 0) begin
            expect_err(code);
        end else begin
            a = addr;
            r = len;
            hold = hold_first;
            while (r > 0) begin
                lim = MAX_CPL_BYTES - int'(a % 64'(RCB_BYTES));
                s = (r < lim) ? r : lim;
                expect_seg(tag, a, s, r, (s == r), hold);
                a = a + 64'(s);
                r = r - s;
                hold = rand_bp ? int'($urandom_range(0, 2)) : 0;
            end
            expect_idle();
        end
    endtask

    vec_t vecs[$];

    initial begin
        // Reset state, sampled while reset is held.
        @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_valid", 64'(cpl_valid), 64'd0);
        chk("rst_last",  64'(cpl_last), 64'd0);
        chk("rst_err",   64'(err_valid), 64'd0);
        chk("rst_cnt",   64'(outstanding_cnt), 64'd0);
        chk("rst_tag",   64'(cpl_tag), 64'd0);
        chk("rst_addr",  cpl_addr, 64'd0);
        chk("rst_len",   64'(cpl_len), 64'd0);
        chk("rst_bc",    64'(cpl_byte_count), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Aligned request: two full segments.
        send_req(5, 64'h2000, 512);
        expect_seg(5, 64'h2000, 256, 512, 1'b0, 0);
        expect_seg(5, 64'h2100, 256, 256, 1'b1, 0);
        expect_idle();

        // Unaligned request: first segment trimmed to the boundary.
        send_req(7, 64'h1030, 300);
        expect_seg(7, 64'h1030, 208, 300, 1'b0, 0);
        expect_seg(7, 64'h1100,  92,  92, 1'b1, 0);
        expect_idle();

        // Backpressure on segment 1, then segment 2 right after release.
        send_req(3, 64'h5000, 512);
        expect_seg(3, 64'h5000, 256, 512, 1'b0, 5);
        expect_seg(3, 64'h5100, 256, 256, 1'b1, 0);
        expect_idle();

        // Short request ending just below a page.
        send_req(9, 64'h3FFC, 4);
        expect_seg(9, 64'h3FFC, 4, 4, 1'b1, 0);
        expect_idle();

        // Reset during the second segment.
        send_req(5, 64'h2000, 512);
        expect_seg(5, 64'h2000, 256, 512, 1'b0, 0);
        chk("pre_rst_valid", 64'(cpl_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(cpl_valid), 64'd0);
        chk("mid_rst_cnt",   64'(outstanding_cnt), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        chk("mid_rst_hold_valid", 64'(cpl_valid), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        send_req(5, 64'h2000, 512);
        expect_seg(5, 64'h2000, 256, 512, 1'b0, 0);
        expect_seg(5, 64'h2100, 256, 256, 1'b1, 0);
        expect_idle();

        // Table of requests: errors, boundaries, wrap.
        vecs.push_back('{300,  64'h0,                 64,   0, 1});
        vecs.push_back('{1,    64'h0,                 0,    0, 3});
        vecs.push_back('{1,    64'h0,                 4100, 0, 3});
        vecs.push_back('{256,  64'h0,                 0,    0, 1});
        vecs.push_back('{1023, 64'h40,                4097, 0, 1});
        vecs.push_back('{255,  64'hFFFF_FFFF_FFFF_FFF0, 300, 1, 0});
        vecs.push_back('{0,    64'h0,                 4096, 0, 0});
        vecs.push_back('{2,    64'h7F,                1,    2, 0});
        vecs.push_back('{4,    64'h1FFF,              4096, 0, 0});
        vecs.push_back('{6,    64'hABC0,              64,   3, 0});
        vecs.push_back('{8,    64'h0,                 4097, 0, 3});
        foreach (vecs[i])
            run_model(vecs[i].tag, vecs[i].addr, vecs[i].len, vecs[i].exp_code,
                      vecs[i].hold, 1'b0);

        // Random requests against the segment-list model.
        for (int n = 0; n < 60; n++) begin
            int tag, len, sel;
            logic [63:0] addr;
            tag = ($urandom_range(0, 9) == 0) ? int'($urandom_range(256, 1023))
                                              : int'($urandom_range(0, 255));
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      len = 0;
            else if (sel == 1) len = int'($urandom_range(4097, 8191));
            else if (sel < 5)  len = int'($urandom_range(1, 300));
            else               len = int'($urandom_range(1, 4096));
            addr = {$urandom, $urandom};
            run_model(tag, addr, len, model_code(tag, len),
                      int'($urandom_range(0, 2)), 1'b1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
